// File: rtl/cr_apb_resp_pkg.sv
// Shared types and constants for the APB register-port completer and its timer.
package cr_apb_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // BUSY marks a backend request still outstanding after the initiator walked away.
  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } busy_e;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;
  localparam int unsigned TIMER_WIDTH     = 16;
  localparam logic [63:0] ERR_RDATA       = '0;

endpackage

// File: rtl/cr_apb_resp_timer.sv
// 16-bit load/increment counter that saturates at all-ones and flags a terminal count.
module cr_apb_resp_timer
  import cr_apb_resp_pkg::*;
#(
  parameter logic [TIMER_WIDTH-1:0] TERMINAL = TIMER_WIDTH'(DEFAULT_TIMEOUT - 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [TIMER_WIDTH-1:0] count_q;
  logic [TIMER_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {TIMER_WIDTH{1'b1}})) begin
      count_d = count_q + TIMER_WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TERMINAL);

endmodule

// File: rtl/cr_apb_resp.sv
// APB3 completer turning each transfer into one strobe/ack request on the register bus.
// A silent backend is completed with an error after TIMEOUT_CYCLES instead of stalling APB.
module cr_apb_resp
  import cr_apb_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] apb_paddr,
  input  logic                  apb_psel,
  input  logic                  apb_penable,
  input  logic                  apb_pwrite,
  input  logic [DATA_WIDTH-1:0] apb_pwdata,
  output logic [DATA_WIDTH-1:0] apb_prdata,
  output logic                  apb_pready,
  output logic                  apb_pslverr,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_wr_stb,
  output logic                  reg_rd_stb,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  input  logic                  reg_ack,
  input  logic                  reg_err,
  output logic                  timeout_evt
);

  state_e                state_q;
  busy_e                 busy_q;
  logic                  held_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [ADDR_WIDTH-1:0] reg_addr_q;
  logic [DATA_WIDTH-1:0] reg_wdata_q;
  logic                  wr_stb_q;
  logic                  rd_stb_q;
  logic                  timeout_evt_q;

  logic waiting_s;
  logic tc_s;
  logic timeout_s;
  logic done_s;
  logic setup_s;

  // held_q remembers a setup phase that arrived while BUSY, so its access phase is still accepted.
  assign waiting_s = (state_q == WAIT) || ((state_q == IDLE) && (busy_q == BUSY));
  assign timeout_s = waiting_s && tc_s && !reg_ack;
  assign done_s    = ((state_q == REQ) || waiting_s) && (reg_ack || timeout_s);
  assign setup_s   = apb_psel && (!apb_penable || held_q);

  cr_apb_resp_timer #(
    .TERMINAL (TIMER_WIDTH'(TIMEOUT_CYCLES - 1))
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == REQ),
    .inc_i  (waiting_s),
    .tc_o   (tc_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busy_q        <= FREE;
      held_q        <= 1'b0;
      write_q       <= 1'b0;
      prdata_q      <= '0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      reg_addr_q    <= '0;
      reg_wdata_q   <= '0;
      wr_stb_q      <= 1'b0;
      rd_stb_q      <= 1'b0;
      timeout_evt_q <= 1'b0;
    end else begin
      wr_stb_q      <= 1'b0;
      rd_stb_q      <= 1'b0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      prdata_q      <= '0;
      timeout_evt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (busy_q == BUSY) begin
            if (apb_psel && !apb_penable) begin
              held_q <= 1'b1;
            end else if (!apb_psel) begin
              held_q <= 1'b0;
            end else begin
              held_q <= held_q;
            end
            if (done_s) begin
              busy_q        <= FREE;
              timeout_evt_q <= timeout_s;
            end else begin
              busy_q <= BUSY;
            end
          end else if (setup_s) begin
            held_q  <= 1'b0;
            write_q <= apb_pwrite;
            if (apb_paddr[1:0] != 2'b00) begin
              state_q   <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
            end else begin
              state_q     <= REQ;
              reg_addr_q  <= apb_paddr;
              reg_wdata_q <= apb_pwdata;
              wr_stb_q    <= apb_pwrite;
              rd_stb_q    <= !apb_pwrite;
            end
          end else begin
            held_q <= 1'b0;
          end
        end
        REQ, WAIT: begin
          if (!apb_psel) begin
            state_q       <= IDLE;
            busy_q        <= done_s ? FREE : BUSY;
            timeout_evt_q <= timeout_s;
          end else if (done_s) begin
            state_q       <= RESP;
            pready_q      <= 1'b1;
            timeout_evt_q <= timeout_s;
            if (reg_ack) begin
              pslverr_q <= reg_err;
              prdata_q  <= write_q ? '0 : reg_rdata;
            end else begin
              pslverr_q <= 1'b1;
              prdata_q  <= DATA_WIDTH'(ERR_RDATA);
            end
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign apb_prdata  = prdata_q;
  assign apb_pready  = pready_q;
  assign apb_pslverr = pslverr_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_wr_stb  = wr_stb_q;
  assign reg_rd_stb  = rd_stb_q;
  assign timeout_evt = timeout_evt_q;

endmodule

// File: tb/tb_cr_apb_resp.sv
// Table-driven bench for cr_apb_resp (TIMEOUT_CYCLES=8) plus hand sequences for abort and reset.
module tb_cr_apb_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] apb_paddr = '0;
  logic        apb_psel = 1'b0;
  logic        apb_penable = 1'b0;
  logic        apb_pwrite = 1'b0;
  logic [31:0] apb_pwdata = '0;
  logic [31:0] apb_prdata;
  logic        apb_pready;
  logic        apb_pslverr;
  logic [19:0] reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr_stb;
  logic        reg_rd_stb;
  logic [31:0] reg_rdata = '0;
  logic        reg_ack = 1'b0;
  logic        reg_err = 1'b0;
  logic        timeout_evt;

  int checks = 0;
  int errors = 0;

  cr_apb_resp #(
    .ADDR_WIDTH     (20),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .apb_paddr   (apb_paddr),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_pwdata  (apb_pwdata),
    .apb_prdata  (apb_prdata),
    .apb_pready  (apb_pready),
    .apb_pslverr (apb_pslverr),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_wr_stb  (reg_wr_stb),
    .reg_rd_stb  (reg_rd_stb),
    .reg_rdata   (reg_rdata),
    .reg_ack     (reg_ack),
    .reg_err     (reg_err),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  // ack_at: cycle after setup edge (0 = strobe cycle) in which reg_ack is driven; -1 = never.
  // exp_cyc: cycle after setup edge in which pready is high.
  typedef struct {
    logic        write;
    logic [19:0] addr;
    logic [31:0] wdata;
    int          ack_at;
    logic [31:0] rdata;
    logic        err;
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_prdata;
    logic        exp_tevt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".prdata"}, apb_prdata, 32'h0);
    check({name, ".ctl"}, {26'h0, apb_pready, apb_pslverr, reg_wr_stb, reg_rd_stb, timeout_evt, 1'b0}, 32'h0);
    check({name, ".reg_addr"}, {12'h0, reg_addr}, 32'h0);
    check({name, ".reg_wdata"}, reg_wdata, 32'h0);
  endtask

  task automatic run_xfer(input string tag, input vec_t v);
    bit aligned;
    int got;
    aligned = (v.addr[1:0] == 2'b00);
    got = -1;
    @(negedge clk);
    check({tag, ".pready_one_cycle"}, {31'h0, apb_pready}, 32'h0);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = v.addr;
    apb_pwrite = v.write; apb_pwdata = v.wdata; reg_ack = 1'b0;
    @(negedge clk);
    apb_penable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k != 0) @(negedge clk);
      check($sformatf("%s.wr_stb@%0d", tag, k), {31'h0, reg_wr_stb}, {31'h0, (k == 0) && aligned && v.write});
      check($sformatf("%s.rd_stb@%0d", tag, k), {31'h0, reg_rd_stb}, {31'h0, (k == 0) && aligned && !v.write});
      if (k == 0 && aligned) begin
        check({tag, ".reg_addr"}, {12'h0, reg_addr}, {12'h0, v.addr});
        if (v.write) check({tag, ".reg_wdata"}, reg_wdata, v.wdata);
      end
      check($sformatf("%s.timeout_evt@%0d", tag, k), {31'h0, timeout_evt}, {31'h0, v.exp_tevt && (k == v.exp_cyc)});
      if (apb_pready) begin
        got = k;
        check({tag, ".pslverr"}, {31'h0, apb_pslverr}, {31'h0, v.exp_err});
        check({tag, ".prdata"}, apb_prdata, v.exp_prdata);
        break;
      end
      check($sformatf("%s.prdata_idle@%0d", tag, k), apb_prdata, 32'h0);
      reg_ack   = (k == v.ack_at);
      reg_rdata = reg_ack ? v.rdata : 32'h0BAD_0BAD;
      reg_err   = reg_ack ? v.err : 1'b1;
    end
    reg_ack = 1'b0;
    check({tag, ".pready_cycle"}, got, v.exp_cyc);
  endtask

  task automatic idle_cycles(input string tag, input int n, input bit stray_ack);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s.quiet@%0d", tag, i), {29'h0, apb_pready, reg_wr_stb, reg_rd_stb}, 32'h0);
      apb_psel = 1'b0; apb_penable = 1'b0;
      reg_ack = stray_ack && (i == 0);
      reg_err = 1'b1;
      reg_rdata = 32'hFEEDFACE;
    end
    reg_ack = 1'b0;
  endtask

  vec_t vecs[9];
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{1'b1, 20'h00010, 32'hA5A5A5A5,  0, 32'hFFFF0000, 1'b0, 1, 1'b0, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 20'h00020, 32'h00000000,  5, 32'h12345678, 1'b0, 6, 1'b0, 32'h12345678, 1'b0};
    vecs[2] = '{1'b0, 20'h00024, 32'h00000000, -1, 32'h00000000, 1'b0, 9, 1'b1, 32'h00000000, 1'b1};
    vecs[3] = '{1'b1, 20'h00013, 32'h55555555, -1, 32'h00000000, 1'b0, 0, 1'b1, 32'h00000000, 1'b0};
    vecs[4] = '{1'b0, 20'h00030, 32'h00000000,  8, 32'hDEADBEEF, 1'b0, 9, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{1'b1, 20'h00034, 32'h01020304,  2, 32'h99999999, 1'b1, 3, 1'b1, 32'h00000000, 1'b0};
    vecs[6] = '{1'b0, 20'h00038, 32'h00000000,  1, 32'hCAFEF00D, 1'b1, 2, 1'b1, 32'hCAFEF00D, 1'b0};
    vecs[7] = '{1'b0, 20'h00002, 32'h00000000, -1, 32'h00000000, 1'b0, 0, 1'b1, 32'h00000000, 1'b0};
    vecs[8] = '{1'b1, 20'h00040, 32'h87654321,  7, 32'h00000000, 1'b0, 8, 1'b0, 32'h00000000, 1'b0};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Back-to-back transfers straight out of the table.
    for (int i = 0; i < 9; i++) run_xfer($sformatf("vec%0d", i), vecs[i]);

    // Timeout, then a late ack in IDLE must be ignored and the next read must be clean.
    v = '{1'b0, 20'h00070, 32'h0, -1, 32'h0, 1'b0, 9, 1'b1, 32'h0, 1'b1};
    run_xfer("late_to", v);
    idle_cycles("stray_ack", 3, 1'b1);
    v = '{1'b0, 20'h00074, 32'h0, 3, 32'h0F0F0F0F, 1'b0, 4, 1'b0, 32'h0F0F0F0F, 1'b0};
    run_xfer("after_stray", v);
    idle_cycles("gap", 2, 1'b0);

    // Abort in WAIT, new setup held off until the outstanding ack is consumed.
    @(negedge clk);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = 20'h00050; apb_pwrite = 1'b0;
    @(negedge clk);
    apb_penable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      check($sformatf("abort.rd_stb@%0d", c), {31'h0, reg_rd_stb}, {31'h0, c == 0});
      check($sformatf("abort.wr_stb@%0d", c), {31'h0, reg_wr_stb}, {31'h0, c == 7});
      check($sformatf("abort.pready@%0d", c), {31'h0, apb_pready}, {31'h0, c == 8});
      if (c == 7) check("abort.reg_addr", {12'h0, reg_addr}, 32'h00000054);
      if (c == 8) check("abort.pslverr", {31'h0, apb_pslverr}, 32'h0);
      if (c == 1) begin
        apb_psel = 1'b0; apb_penable = 1'b0;
      end else if (c == 2) begin
        apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = 20'h00054;
        apb_pwrite = 1'b1; apb_pwdata = 32'h11112222;
      end else if (c >= 3 && c <= 8) begin
        apb_penable = 1'b1;
      end else if (c == 9) begin
        apb_psel = 1'b0; apb_penable = 1'b0;
      end
      reg_ack   = (c == 5) || (c == 7);
      reg_err   = (c == 5);
      reg_rdata = 32'h0BAD_0BAD;
    end
    reg_ack = 1'b0;

    // Reset pulsed mid-WAIT: outputs clear at once and the interrupted transfer never re-strobes.
    idle_cycles("pre_rst", 1, 1'b0);
    @(negedge clk);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = 20'h00060; apb_pwrite = 1'b1; apb_pwdata = 32'h77777777;
    @(negedge clk);
    apb_penable = 1'b1;
    check("rst.strobe_before", {31'h0, reg_wr_stb}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("rst.quiet@%0d", c), {29'h0, apb_pready, reg_wr_stb, reg_rd_stb}, 32'h0);
    end
    apb_psel = 1'b0; apb_penable = 1'b0;
    v = '{1'b1, 20'h00064, 32'h3C3C3C3C, 0, 32'h0, 1'b0, 1, 1'b0, 32'h0, 1'b0};
    run_xfer("post_rst", v);
    idle_cycles("tail", 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
